// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare plus iterative MULTU and DIVU.
// Latency: 1 cycle for single-cycle ops, illegal ops and DIVU by zero; N+1 cycles for MULTU/DIVU.
// Backpressure: busy is high while iterating; start is ignored then, with no queuing.
module alu_mc #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] z,
    output logic [N-1:0] hi,
    output logic         zero,
    output logic         overflow,
    output logic         div_by_zero,
    output logic         illegal_op
);
    localparam int SHW = $clog2(N);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t         state_q, state_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    // acc: product high half / partial remainder; lo: multiplier or dividend shifting out,
    // result bits shifting in; opb: multiplicand or divisor, held for the whole operation.
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [N-1:0]   opb_q, opb_d;

    logic [N-1:0]   sc_z, sc_hi;
    logic           sc_ovf, sc_dbz, sc_ill;
    logic [N-1:0]   sum, diff;

    logic           res_ld;
    logic [N-1:0]   res_z, res_hi;
    logic           res_ovf, res_dbz, res_ill;

    logic [N:0]     mul_sum;
    logic [N-1:0]   mul_acc, mul_lo;
    logic [N:0]     div_sh;
    logic           div_ge;
    logic [N-1:0]   div_diff, div_rem, div_quo;

    assign busy = (state_q != IDLE);
    assign sum  = a + b;
    assign diff = a - b;

    // Single-cycle result and flags, computed from the live operands at the accept edge
    always_comb begin
        sc_z   = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dbz = 1'b0;
        sc_ill = 1'b0;
        case (op)
            OP_AND:  sc_z = a & b;
            OP_OR:   sc_z = a | b;
            OP_XOR:  sc_z = a ^ b;
            OP_NOR:  sc_z = ~(a | b);
            OP_ADD: begin
                sc_z   = sum;
                sc_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                sc_z   = diff;
                sc_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_SLT:  sc_z = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_z = {{(N-1){1'b0}}, (a < b)};
            OP_SLL:  sc_z = a << b[SHW-1:0];
            OP_SRL:  sc_z = a >> b[SHW-1:0];
            OP_SRA:  sc_z = N'($signed(a) >>> b[SHW-1:0]);
            OP_MULU: sc_z = '0;   // never loaded from here; goes iterative
            OP_DIVU: begin        // only loaded from here when b == 0
                sc_z   = '1;
                sc_hi  = a;
                sc_dbz = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // One shift-add multiply step and one restoring divide step on the held operands
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(N+1){1'b0}});
        mul_acc  = mul_sum[N:1];
        mul_lo   = {mul_sum[0], lo_q[N-1:1]};
        div_sh   = {acc_q, lo_q[N-1]};
        div_ge   = (div_sh >= {1'b0, opb_q});
        div_diff = div_sh[N-1:0] - opb_q;   // exact when div_ge: true difference is below opb
        div_rem  = div_ge ? div_diff : div_sh[N-1:0];
        div_quo  = {lo_q[N-2:0], div_ge};
    end

    // Next-state, iteration datapath and result-load decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        res_ld  = 1'b0;
        res_z   = sc_z;
        res_hi  = sc_hi;
        res_ovf = sc_ovf;
        res_dbz = sc_dbz;
        res_ill = sc_ill;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_MULU) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                        lo_d    = b;
                        opb_d   = a;
                    end else if (op == OP_DIVU && b != '0) begin
                        state_d = DIV;
                        cnt_d   = '0;
                        acc_d   = '0;
                        lo_d    = a;
                        opb_d   = b;
                    end else begin
                        res_ld = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = mul_acc;
                lo_d  = mul_lo;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(N-1)) begin
                    state_d = IDLE;
                    res_ld  = 1'b1;
                    res_z   = mul_lo;
                    res_hi  = mul_acc;
                    res_ovf = 1'b0;
                    res_dbz = 1'b0;
                    res_ill = 1'b0;
                end
            end
            DIV: begin
                acc_d = div_rem;
                lo_d  = div_quo;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(N-1)) begin
                    state_d = IDLE;
                    res_ld  = 1'b1;
                    res_z   = div_quo;
                    res_hi  = div_rem;
                    res_ovf = 1'b0;
                    res_dbz = 1'b0;
                    res_ill = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and iteration registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
        end
    end

    // Result/flag registers: updated only on completion, done pulses for that one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done        <= 1'b0;
            z           <= '0;
            hi          <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            done <= res_ld;
            if (res_ld) begin
                z           <= res_z;
                hi          <= res_hi;
                zero        <= (res_z == '0);
                overflow    <= res_ovf;
                div_by_zero <= res_dbz;
                illegal_op  <= res_ill;
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vectors plus random operands against a behavioural model.
// Latency: checks done timing of 1 cycle (single ops) and N+1 cycles (MULTU/DIVU).
// Backpressure: checks start during busy is ignored and a start in the done cycle is accepted.
module tb_alu_mc;
    localparam int N = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy, done, zero, overflow, div_by_zero, illegal_op;
    logic [N-1:0] z, hi;
    logic [67:0]  obs;

    int n_checks = 0;
    int n_fail = 0;

    alu_mc #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .z(z), .hi(hi), .zero(zero),
        .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;
    assign obs = {z, hi, zero, overflow, div_by_zero, illegal_op};

    // Behavioural reference: plain 64-bit arithmetic on the operation's definition
    function automatic logic [67:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] rz, rh;
        logic ov, dz, il;
        longint sx, sy, r;
        logic [63:0] p;
        int sh;
        rz = 0; rh = 0; ov = 0; dz = 0; il = 0; r = 0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y[4:0]);
        case (o)
            4'd0:  rz = x & y;
            4'd1:  rz = x | y;
            4'd3:  rz = x ^ y;
            4'd10: rz = ~(x | y);
            4'd2:  begin r = sx + sy; rz = r[31:0]; ov = (r > SMAX) || (r < SMIN); end
            4'd6:  begin r = sx - sy; rz = r[31:0]; ov = (r > SMAX) || (r < SMIN); end
            4'd7:  rz = (sx < sy) ? 32'd1 : 32'd0;
            4'd9:  rz = (x < y) ? 32'd1 : 32'd0;
            4'd4:  begin p = {32'd0, x} << sh; rz = p[31:0]; end
            4'd5:  rz = x >> sh;
            4'd8:  begin r = sx >>> sh; rz = r[31:0]; end
            4'd12: begin p = {32'd0, x} * {32'd0, y}; rz = p[31:0]; rh = p[63:32]; end
            4'd13: begin
                if (y == 0) begin rz = 32'hFFFFFFFF; rh = x; dz = 1; end
                else begin rz = x / y; rh = x % y; end
            end
            default: il = 1;
        endcase
        return {rz, rh, (rz == 32'd0), ov, dz, il};
    endfunction

    // Present one start pulse; returns at the negedge just after the accept edge
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done from cycle 1 after accept; cyc = cycle done was seen (-1 on timeout)
    task automatic wait_done(output int cyc, output int nbusy);
        cyc = 1; nbusy = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, obs} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", {busy, done, obs});
        end
        reset = 1'b0;
    endtask

    task automatic test_directed_single;
        logic [3:0]  t_op [9] = '{4'd2, 4'd6, 4'd7, 4'd9, 4'd8, 4'd4, 4'd13, 4'd6, 4'd10};
        logic [31:0] t_a  [9] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                  32'd1, 32'd100, 32'h80000000, 32'd0};
        logic [31:0] t_b  [9] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd31, 32'h21, 32'd0, 32'd1, 32'd0};
        logic [31:0] t_z  [9] = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd2,
                                  32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_hi [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd100, 32'd0, 32'd0};
        // {zero, overflow, div_by_zero, illegal_op}
        logic [3:0]  t_fl [9] = '{4'b0100, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000,
                                  4'b0010, 4'b0100, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0 || obs !== {t_z[i], t_hi[i], t_fl[i]}) begin
                n_fail++;
                $display("FAIL directed_%0d op=%h: got done=%b busy=%b res=%h expected done=1 busy=0 res=%h",
                         i, t_op[i], done, busy, obs, {t_z[i], t_hi[i], t_fl[i]});
            end
        end
    endtask

    task automatic test_random_single;
        logic [3:0] ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        logic [3:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(10, 0)];
            x = $urandom();
            y = (i % 5 == 0) ? x : $urandom();
            if (i % 7 == 0) x = 32'h80000000;
            issue(o, x, y);
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0 || obs !== model(o, x, y)) begin
                n_fail++;
                $display("FAIL random_single op=%h a=%h b=%h: got done=%b res=%h expected done=1 res=%h",
                         o, x, y, done, obs, model(o, x, y));
            end
        end
    endtask

    task automatic test_multicycle;
        logic [3:0]  o;
        logic [31:0] x, y;
        int cyc, nb;
        for (int i = 0; i < 8; i++) begin
            o = (i % 2 == 0) ? 4'd12 : 4'd13;
            x = $urandom();
            y = (i % 4 == 3) ? $urandom_range(1000, 1) : $urandom();
            if (i == 0) begin x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; end
            if (i == 1) begin x = 32'd100; y = 32'd7; end
            if (y == 0) y = 1;
            issue(o, x, y);
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL multi_first_cycle_%0d: got busy=%b done=%b expected busy=1 done=0", i, busy, done);
            end
            wait_done(cyc, nb);
            n_checks++;
            if (cyc != 33 || nb != 32 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL multi_timing_%0d: got done_cycle=%0d busy_cycles=%0d busy=%b expected 33 32 0",
                         i, cyc, nb, busy);
            end
            n_checks++;
            if (obs !== model(o, x, y)) begin
                n_fail++;
                $display("FAIL multi_result_%0d op=%h a=%h b=%h: got %h expected %h", i, o, x, y, obs, model(o, x, y));
            end
            if (i == 0) begin
                n_checks++;
                if (z !== 32'h00000001 || hi !== 32'hFFFFFFFE) begin
                    n_fail++;
                    $display("FAIL multu_max: got hi=%h z=%h expected hi=fffffffe z=00000001", hi, z);
                end
            end
            if (i == 1) begin
                n_checks++;
                if (z !== 32'd14 || hi !== 32'd2) begin
                    n_fail++;
                    $display("FAIL divu_100_7: got z=%0d hi=%0d expected z=14 hi=2", z, hi);
                end
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse_%0d: got done=%b expected 0", i, done);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int cyc;
        issue(4'd12, 32'd3, 32'd4);
        cyc = 1;
        while (cyc < 5) begin @(negedge clk); cyc++; end
        start = 1'b1; op = 4'd2; a = 32'd100; b = 32'd200;
        @(negedge clk); cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        n_checks++;
        if (cyc != 33 || obs !== {32'd12, 32'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL busy_ignore: got cycle=%0d res=%h expected cycle=33 res=%h", cyc, obs, {32'd12, 32'd0, 4'b0000});
        end
        start = 1'b1; op = 4'd2; a = 32'd10; b = 32'd20;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || z !== 32'd30 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL start_in_done_cycle: got done=%b z=%0d hi=%0d expected done=1 z=30 hi=0", done, z, hi);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  bo [4] = '{4'd2, 4'd0, 4'd6, 4'd5};
        logic [31:0] ba [4], bb [4];
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ba[i] = $urandom(); bb[i] = $urandom();
            start = 1'b1; op = bo[i]; a = ba[i]; b = bb[i];
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || obs !== model(bo[i], ba[i], bb[i])) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: got done=%b res=%h expected done=1 res=%h",
                         i, done, obs, model(bo[i], ba[i], bb[i]));
            end
        end
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_idle: got done=%b expected 0", done);
        end
    endtask

    task automatic test_reset_mid_op;
        int cyc, ndone;
        issue(4'd13, 32'd100, 32'd7);
        cyc = 1;
        while (cyc < 10) begin @(negedge clk); cyc++; end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, obs} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got %h expected 0", {busy, done, obs});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL no_done_after_abort: got %0d active cycles expected 0", ndone);
        end
        issue(4'b1111, 32'h12345678, 32'h9ABCDEF0);
        n_checks++;
        if (done !== 1'b1 || obs !== {32'd0, 32'd0, 4'b1001}) begin
            n_fail++;
            $display("FAIL illegal_op: got done=%b res=%h expected done=1 res=%h", done, obs, {32'd0, 32'd0, 4'b1001});
        end
    endtask

    initial begin
        test_reset;
        test_directed_single;
        test_random_single;
        test_multicycle;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid_op;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the MIPS datapath. It keeps the existing single-cycle op encodings (AND/OR/ADD/SUB/SLT) and adds XOR, NOR, shifts, unsigned compare, an iterative unsigned multiply and an iterative unsigned divide. It uses a start/busy/done handshake, registered results with HI/LO outputs, and status flags. It sits in the execute stage; control stalls on busy.

Parameters:
N, 32, operand/result width (N >= 4, power of 2)
SHW, $clog2(N), derived (localparam): shift-amount width taken from b[SHW-1:0]

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  4  operation select (encoding below)
a  input  N  operand A
b  input  N  operand B
busy  output  1  iterative op in progress
done  output  1  one-cycle pulse: z/hi/flags updated this cycle
z  output  N  result / LO (product low, quotient)
hi  output  N  HI (product high, remainder); 0 for other ops
zero  output  1  z == 0
overflow  output  1  signed overflow, ADD/SUB only
div_by_zero  output  1  DIVU with b == 0
illegal_op  output  1  unrecognised op

Behaviour:
- Op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 XOR, 1010 NOR
  - 0100 SLL, 0101 SRL, 1000 SRA (shift a by b[SHW-1:0])
  - 1001 SLTU, 1100 MULTU, 1101 DIVU
  - all others illegal
- Reset: asynchronous. All outputs go to 0 immediately, the FSM goes to IDLE, and the internal accumulators and counter clear. Reset mid-MULTU/DIVU aborts the op; no done is ever produced for it.
- FSM: IDLE, MUL, DIV.
  - Accept = rising edge with start=1 in IDLE; a, b and op are captured at that edge.
  - Single-cycle ops, illegal ops and DIVU with b=0: result and flags are registered at the accept edge; done=1 for the following cycle; busy stays 0. Latency 1.
  - MULTU/DIVU: enter MUL/DIV at the accept edge with counter=0. One bit is processed per edge for N edges. At the Nth iteration edge the FSM returns to IDLE and registers z/hi/flags with done=1. busy=1 for exactly N cycles after accept; done appears N+1 cycles after accept, with busy=0 in that cycle.
- start while busy=1 is ignored entirely; no queuing, and captured operands are unchanged. start may be asserted in the done cycle; that is a new accept.
- Back-to-back single-cycle ops give done=1 on consecutive cycles.
- Outputs hold their last values until the next completion. done is 0 except on the completion cycle.
- Arithmetic (N-bit, wrap-around):
  - ADD/SUB: overflow = sign(a) equals sign(±b) and sign(z) differs.
  - SLT/SLTU: z = {N-1 zeros, result bit}.
  - SRA replicates a[N-1].
  - MULTU: shift-add; {hi,z} = a*b, full 2N bits.
  - DIVU: restoring; z = a/b, hi = a%b.
  - DIVU with b=0: z = all ones, hi = a, div_by_zero=1.
- Flags are recomputed on every completion.
  - zero reflects z for all ops.
  - overflow is 0 except ADD/SUB.
  - div_by_zero is 0 except DIVU with b=0.
  - illegal_op=1 with z=0 and hi=0 for illegal encodings.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> next cycle done=1, z=0x80000000, overflow=1, zero=0. SUB a=5, b=5 -> z=0, zero=1, overflow=0.
- SLT a=0xFFFFFFFF, b=1 -> z=1. SLTU with the same operands -> z=0. SRA a=0x80000000, b=31 -> z=0xFFFFFFFF. SLL a=1, b=0x21 (uses b[4:0]=1) -> z=2.
- MULTU a=b=0xFFFFFFFF -> busy high cycles 1..32, done at cycle 33, hi=0xFFFFFFFE, z=0x00000001.
- DIVU a=100, b=7 -> done at cycle 33, z=14, hi=2. DIVU a=100, b=0 -> done at cycle 1, busy never high, z=0xFFFFFFFF, hi=100, div_by_zero=1.
- Start MULTU 3*4, assert start with ADD at cycle 5 -> ignored. Done at cycle 33 with z=12, hi=0. An ADD issued in the done cycle completes the next cycle.
- Assert reset at cycle 10 of DIVU -> all outputs 0 immediately, no done afterwards. After release, op=1111 -> done, illegal_op=1, z=0, zero=1.
